// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register address width and
// the hazard controller state encoding.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        HZ_RUN,
        HZ_MC_WAIT
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: load-use stalls, taken-branch
// squashes and multi-cycle EX waits with a timeout.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic [REG_ADDR_W-1:0] rd_exe,
    input  logic                  memread_exe,
    input  logic                  mc_op_exe,
    input  logic                  branch_taken_exe,
    input  logic                  mc_done,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  stall_exe,
    output logic                  bubble_exe,
    output logic                  bubble_mem,
    output logic                  mc_start,
    output logic                  mc_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    // Last wait count before giving up; the start cycle is the
    // first stall, so MC_TIMEOUT-1 wait cycles follow it.
    localparam logic [WW-1:0] LIM = WW'(MC_TIMEOUT - 2);

    hz_state_e     state;
    hz_state_e     state_nxt;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_nxt;
    logic          err_set;
    logic          lu_haz;
    logic          rs1_hit;
    logic          rs2_hit;

    assign rs1_hit = rs1_used_id && (rs1_id == rd_exe);
    assign rs2_hit = rs2_used_id && (rs2_id == rd_exe);
    assign lu_haz  = memread_exe && (rd_exe != '0)
                  && (rs1_hit || rs2_hit);

    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        err_set    = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_id   = 1'b0;
        stall_exe  = 1'b0;
        bubble_exe = 1'b0;
        bubble_mem = 1'b0;
        mc_start   = 1'b0;
        unique case (state)
            HZ_RUN: begin
                if (branch_taken_exe) begin
                    flush_id   = 1'b1;
                    bubble_exe = 1'b1;
                end else if (mc_op_exe) begin
                    mc_start   = 1'b1;
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_exe  = 1'b1;
                    bubble_mem = 1'b1;
                    state_nxt  = HZ_MC_WAIT;
                    wcnt_nxt   = '0;
                end else if (lu_haz) begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    bubble_exe = 1'b1;
                end
            end
            HZ_MC_WAIT: begin
                if (mc_done) begin
                    state_nxt = HZ_RUN;
                end else begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_exe  = 1'b1;
                    bubble_mem = 1'b1;
                    if (wcnt == LIM) begin
                        err_set   = 1'b1;
                        state_nxt = HZ_RUN;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
        endcase
        if (rst) begin
            stall_if   = 1'b0;
            stall_id   = 1'b0;
            flush_id   = 1'b0;
            stall_exe  = 1'b0;
            bubble_exe = 1'b0;
            bubble_mem = 1'b0;
            mc_start   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HZ_RUN;
            wcnt   <= '0;
            mc_err <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (err_set) begin
                mc_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (stall_if),
        .count(stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (flush_id),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, corner sequences and
// random stimulus against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MC_TO = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       mc;
        logic       br;
        logic       done;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [6:0] e;
    } row_t;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             rs1_used_id;
    logic             rs2_used_id;
    logic [4:0]       rd_exe;
    logic             memread_exe;
    logic             mc_op_exe;
    logic             branch_taken_exe;
    logic             mc_done;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             stall_exe;
    logic             bubble_exe;
    logic             bubble_mem;
    logic             mc_start;
    logic             mc_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_wait   = 0;
    int m_waited = 0;
    bit m_err    = 0;
    int m_sc     = 0;
    int m_fc     = 0;

    hazard_ctrl #(
        .CNT_W     (CNT_W),
        .MC_TIMEOUT(MC_TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_exe          (rd_exe),
        .memread_exe     (memread_exe),
        .mc_op_exe       (mc_op_exe),
        .branch_taken_exe(branch_taken_exe),
        .mc_done         (mc_done),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .stall_exe       (stall_exe),
        .bubble_exe      (bubble_exe),
        .bubble_mem      (bubble_mem),
        .mc_start        (mc_start),
        .mc_err          (mc_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input int a1, input int a2,
        input logic b1, input logic b2, input int d,
        input logic l, input logic m, input logic b,
        input logic dn);
        vec_t v;
        v.rst = r;
        v.r1 = 5'(a1);
        v.r2 = 5'(a2);
        v.u1 = b1;
        v.u2 = b2;
        v.rd = 5'(d);
        v.ld = l;
        v.mc = m;
        v.br = b;
        v.done = dn;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // {stall_if,stall_id,flush_id,stall_exe,bubble_exe,bubble_mem,mc_start}
    function automatic logic [6:0] model_out(input vec_t v);
        bit lu;
        lu = v.ld && (v.rd != 0)
          && ((v.u1 && v.r1 == v.rd) || (v.u2 && v.r2 == v.rd));
        if (v.rst) return 7'b0;
        if (m_wait) return v.done ? 7'b0 : 7'b1101010;
        if (v.br) return 7'b0010100;
        if (v.mc) return 7'b1101011;
        if (lu) return 7'b1100100;
        return 7'b0;
    endfunction

    task automatic model_step(input vec_t v, input logic [6:0] e);
        if (v.rst) begin
            m_wait = 0;
            m_waited = 0;
            m_err = 0;
            m_sc = 0;
            m_fc = 0;
            return;
        end
        if (e[6]) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        if (e[4]) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        if (m_wait) begin
            if (v.done) begin
                m_wait = 0;
            end else begin
                m_waited++;
                if (m_waited == MC_TO - 1) begin
                    m_err = 1;
                    m_wait = 0;
                end
            end
        end else if (!v.br && v.mc) begin
            m_wait = 1;
            m_waited = 0;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycle(input vec_t v, output logic [6:0] o);
        logic [6:0] e;
        rst = v.rst;
        rs1_id = v.r1;
        rs2_id = v.r2;
        rs1_used_id = v.u1;
        rs2_used_id = v.u2;
        rd_exe = v.rd;
        memread_exe = v.ld;
        mc_op_exe = v.mc;
        branch_taken_exe = v.br;
        mc_done = v.done;
        #1;
        o = {stall_if, stall_id, flush_id, stall_exe,
             bubble_exe, bubble_mem, mc_start};
        e = model_out(v);
        chk("ctrl", int'(o), int'(e));
        chk("mc_err", int'(mc_err), int'(m_err));
        chk("stall_cnt", int'(stall_cnt), m_sc);
        chk("flush_cnt", int'(flush_cnt), m_fc);
        model_step(v, e);
        @(negedge clk);
    endtask

    row_t       tbl[12];
    logic [6:0] o;
    int         nst;
    int         nstart;
    vec_t       rv;

    initial begin
        tbl[0]  = '{mk(0, 1, 5, 0, 1, 5, 1, 0, 0, 0), 7'b1100100};
        tbl[1]  = '{idle(), 7'b0000000};
        tbl[2]  = '{mk(0, 0, 3, 1, 1, 0, 1, 0, 0, 0), 7'b0000000};
        tbl[3]  = '{mk(0, 5, 2, 0, 1, 5, 1, 0, 0, 0), 7'b0000000};
        tbl[4]  = '{mk(0, 7, 0, 1, 0, 7, 1, 0, 1, 0), 7'b0010100};
        tbl[5]  = '{mk(0, 0, 0, 0, 0, 3, 0, 1, 1, 0), 7'b0010100};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 3, 0, 1, 0, 0), 7'b1101011};
        tbl[7]  = '{mk(0, 3, 0, 1, 0, 3, 1, 1, 1, 0), 7'b1101010};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 3, 0, 1, 1, 1), 7'b0000000};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 4, 0, 1, 0, 0), 7'b1101011};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 4, 0, 1, 0, 1), 7'b0000000};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 7'b0000000};

        rst = 1'b1;
        {rs1_id, rs2_id, rd_exe} = '0;
        {rs1_used_id, rs2_used_id, memread_exe} = '0;
        {mc_op_exe, branch_taken_exe, mc_done} = '0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        cycle(idle(), o);
        chk("reset_ctrl", int'(o), 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].v, o);
            chk($sformatf("tbl%0d", i), int'(o), int'(tbl[i].e));
        end
        cycle(idle(), o);
        chk("tbl_stalls", int'(stall_cnt), 4);
        chk("tbl_flushes", int'(flush_cnt), 2);

        // latency-4 multi-cycle op
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), o);
        nst = 0;
        nstart = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, k == 4), o);
            nst += int'(o[6]);
            nstart += int'(o[0]);
        end
        cycle(idle(), o);
        chk("mc4_stalls", nst, 4);
        chk("mc4_starts", nstart, 1);
        chk("mc4_cnt", int'(stall_cnt), 4);
        chk("mc4_run", int'(o), 0);

        // timeout with no mc_done
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), o);
        nst = 0;
        for (int k = 0; k < MC_TO; k++) begin
            cycle(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0), o);
            nst += int'(o[6]);
        end
        chk("to_stalls", nst, MC_TO);
        cycle(idle(), o);
        chk("to_err", int'(mc_err), 1);
        chk("to_run", int'(o), 0);
        cycle(idle(), o);
        chk("to_sticky", int'(mc_err), 1);

        // reset in the third wait cycle, then a late mc_done
        cycle(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0), o);
        cycle(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0), o);
        cycle(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0), o);
        cycle(mk(1, 0, 0, 0, 0, 2, 0, 1, 0, 0), o);
        chk("rst_out", int'(o), 0);
        cycle(idle(), o);
        chk("rst_err", int'(mc_err), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), o);
        chk("late_done", int'(o), 0);

        // random traffic
        for (int k = 0; k < 500; k++) begin
            rv = mk($urandom_range(59) == 0,
                    $urandom_range(3), $urandom_range(3),
                    1'($urandom), 1'($urandom),
                    $urandom_range(3), 1'($urandom),
                    $urandom_range(5) == 0,
                    $urandom_range(5) == 0,
                    $urandom_range(3) == 0);
            cycle(rv, o);
        end

        // stall counter saturation
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), o);
        for (int k = 0; k < 20; k++) begin
            cycle(mk(0, 6, 0, 1, 0, 6, 1, 0, 0, 0), o);
        end
        cycle(idle(), o);
        chk("sat_cnt", int'(stall_cnt), CMAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
